// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared RV32I core constants: control bundle layout, encodings, opcodes
package core_pkg;

    localparam int CTRL_W = 12;

    // Control bundle field positions
    localparam int CTRL_REGWRITE   = 11;
    localparam int CTRL_RESSRC_HI  = 10;
    localparam int CTRL_RESSRC_LO  = 9;
    localparam int CTRL_MEMWRITE   = 8;
    localparam int CTRL_JUMP       = 7;
    localparam int CTRL_BRANCH_HI  = 6;
    localparam int CTRL_BRANCH_LO  = 5;
    localparam int CTRL_ALUSRC     = 4;
    localparam int CTRL_SEL_ADDER  = 3;
    localparam int CTRL_ALUCTRL_HI = 2;
    localparam int CTRL_ALUCTRL_LO = 0;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - event counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Advance by one unless already at the ceiling
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - decode-to-execute pipeline register with stall, flush and perf counters
module id_ex_pipe_reg
    import core_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              StallE,
    input  logic              FlushE,
    input  logic              ValidD,
    input  logic [CTRL_W-1:0] CtrlD,
    input  logic [XLEN-1:0]   RD1D,
    input  logic [XLEN-1:0]   RD2D,
    input  logic [XLEN-1:0]   ImmExtD,
    input  logic [XLEN-1:0]   PCD,
    input  logic [XLEN-1:0]   PCPlus4D,
    input  logic [4:0]        Rs1D,
    input  logic [4:0]        Rs2D,
    input  logic [4:0]        RdD,
    input  logic [2:0]        Funct3D,
    output logic              ValidE,
    output logic [CTRL_W-1:0] CtrlE,
    output logic [XLEN-1:0]   RD1E,
    output logic [XLEN-1:0]   RD2E,
    output logic [XLEN-1:0]   ImmExtE,
    output logic [XLEN-1:0]   PCE,
    output logic [XLEN-1:0]   PCPlus4E,
    output logic [4:0]        Rs1E,
    output logic [4:0]        Rs2E,
    output logic [4:0]        RdE,
    output logic [2:0]        Funct3E,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [XLEN-1:0]   rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
    logic [XLEN-1:0]   pc_q, pc_d, pc4_q, pc4_d;
    logic [4:0]        rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [2:0]        f3_q, f3_d;

    // Next state: flush wins over stall; an invalid load keeps data but drops side effects
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        imm_d   = imm_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        f3_d    = f3_q;
        if (FlushE) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            rd1_d   = '0;
            rd2_d   = '0;
            imm_d   = '0;
            pc_d    = '0;
            pc4_d   = '0;
            rs1_d   = '0;
            rs2_d   = '0;
            rd_d    = '0;
            f3_d    = '0;
        end else if (!StallE) begin
            valid_d = ValidD;
            ctrl_d  = ValidD ? CtrlD : '0;
            rd_d    = ValidD ? RdD : 5'd0;
            rd1_d   = RD1D;
            rd2_d   = RD2D;
            imm_d   = ImmExtD;
            pc_d    = PCD;
            pc4_d   = PCPlus4D;
            rs1_d   = Rs1D;
            rs2_d   = Rs2D;
            f3_d    = Funct3D;
        end
    end

    // Pipeline register bank
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
            pc4_q   <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            f3_q    <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            f3_q    <= f3_d;
        end
    end

    assign ValidE   = valid_q;
    assign CtrlE    = ctrl_q;
    assign RD1E     = rd1_q;
    assign RD2E     = rd2_q;
    assign ImmExtE  = imm_q;
    assign PCE      = pc_q;
    assign PCPlus4E = pc4_q;
    assign Rs1E     = rs1_q;
    assign Rs2E     = rs2_q;
    assign RdE      = rd_q;
    assign Funct3E  = f3_q;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (StallE & ~FlushE),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (FlushE),
        .count (bubble_cnt)
    );

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb/tb_id_ex_pipe_reg.sv - self-checking bench for id_ex_pipe_reg against a behavioural model
module tb_id_ex_pipe_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        StallE, FlushE, ValidD;
    logic [11:0] CtrlD;
    logic [31:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic [2:0]  Funct3D;

    logic        ValidE, ValidE4;
    logic [11:0] CtrlE, CtrlE4;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [31:0] RD1E4, RD2E4, ImmExtE4, PCE4, PCPlus4E4;
    logic [4:0]  Rs1E, Rs2E, RdE, Rs1E4, Rs2E4, RdE4;
    logic [2:0]  Funct3E, Funct3E4;
    logic [15:0] stall_cnt, bubble_cnt;
    logic [3:0]  stall_cnt4, bubble_cnt4;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: what Execute should see after each edge
    typedef struct {
        bit          valid;
        bit [11:0]   ctrl;
        bit [31:0]   rd1, rd2, imm, pc, pc4;
        bit [4:0]    rs1, rs2, rd;
        bit [2:0]    f3;
    } e_stage_t;

    e_stage_t m;
    int       m_stalls, m_bubbles;

    always #5 clk = ~clk;

    id_ex_pipe_reg dut (
        .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
        .CtrlD(CtrlD), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD),
        .PCPlus4D(PCPlus4D), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .Funct3D(Funct3D),
        .ValidE(ValidE), .CtrlE(CtrlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .Funct3E(Funct3E), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    id_ex_pipe_reg #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
        .CtrlD(CtrlD), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD),
        .PCPlus4D(PCPlus4D), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .Funct3D(Funct3D),
        .ValidE(ValidE4), .CtrlE(CtrlE4), .RD1E(RD1E4), .RD2E(RD2E4), .ImmExtE(ImmExtE4),
        .PCE(PCE4), .PCPlus4E(PCPlus4E4), .Rs1E(Rs1E4), .Rs2E(Rs2E4), .RdE(RdE4),
        .Funct3E(Funct3E4), .stall_cnt(stall_cnt4), .bubble_cnt(bubble_cnt4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v, input int bits);
        int top;
        top = (1 << bits) - 1;
        return (v > top) ? top : v;
    endfunction

    task automatic model_reset();
        m = '{default: '0};
        m_stalls  = 0;
        m_bubbles = 0;
    endtask

    // One clock edge of the reference: bubble, hold or capture
    task automatic model_edge();
        if (!rst) begin
            model_reset();
        end else if (FlushE) begin
            m = '{default: '0};
            m_bubbles++;
        end else if (StallE) begin
            m_stalls++;
        end else begin
            m.valid = ValidD;
            m.ctrl  = ValidD ? CtrlD : 12'h0;
            m.rd    = ValidD ? RdD : 5'h0;
            m.rd1   = RD1D;
            m.rd2   = RD2D;
            m.imm   = ImmExtD;
            m.pc    = PCD;
            m.pc4   = PCPlus4D;
            m.rs1   = Rs1D;
            m.rs2   = Rs2D;
            m.f3    = Funct3D;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".valid"}, ValidE, m.valid);
        check({tag, ".ctrl"}, CtrlE, m.ctrl);
        check({tag, ".rd1"}, RD1E, m.rd1);
        check({tag, ".rd2"}, RD2E, m.rd2);
        check({tag, ".imm"}, ImmExtE, m.imm);
        check({tag, ".pc"}, PCE, m.pc);
        check({tag, ".pc4"}, PCPlus4E, m.pc4);
        check({tag, ".rs1"}, Rs1E, m.rs1);
        check({tag, ".rs2"}, Rs2E, m.rs2);
        check({tag, ".rd"}, RdE, m.rd);
        check({tag, ".f3"}, Funct3E, m.f3);
        check({tag, ".stall_cnt"}, stall_cnt, sat(m_stalls, 16));
        check({tag, ".bubble_cnt"}, bubble_cnt, sat(m_bubbles, 16));
        check({tag, ".d4_front"}, {ValidE4, CtrlE4, RdE4, Rs1E4, Rs2E4, Funct3E4},
              {m.valid, m.ctrl, m.rd, m.rs1, m.rs2, m.f3});
        check({tag, ".d4_rd12"}, {RD1E4, RD2E4}, {m.rd1, m.rd2});
        check({tag, ".d4_imm_pc"}, {ImmExtE4, PCE4}, {m.imm, m.pc});
        check({tag, ".d4_pc4"}, PCPlus4E4, m.pc4);
        check({tag, ".stall_cnt4"}, stall_cnt4, sat(m_stalls, 4));
        check({tag, ".bubble_cnt4"}, bubble_cnt4, sat(m_bubbles, 4));
    endtask

    // Inputs change at the falling edge; the model and DUT both sample at the rising edge
    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic rand_d();
        ValidD   = ($urandom_range(0, 9) < 8);
        CtrlD    = 12'($urandom);
        RD1D     = $urandom;
        RD2D     = $urandom;
        ImmExtD  = $urandom;
        PCD      = $urandom;
        PCPlus4D = $urandom;
        Rs1D     = 5'($urandom);
        Rs2D     = 5'($urandom);
        RdD      = 5'($urandom);
        Funct3D  = 3'($urandom);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".front"}, {ValidE, CtrlE, RdE, Rs1E, Rs2E, Funct3E}, 64'h0);
        check({tag, ".rd12"}, {RD1E, RD2E}, 64'h0);
        check({tag, ".imm_pc"}, {ImmExtE, PCE}, 64'h0);
        check({tag, ".pc4"}, PCPlus4E, 64'h0);
        check({tag, ".cnts"}, {stall_cnt, bubble_cnt, stall_cnt4, bubble_cnt4}, 64'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cycle("rst_hold");
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        rst = 1'b0; StallE = 1'b1; FlushE = 1'b0;
        ValidD = 1'b1; CtrlD = 12'hFFF; RD1D = 32'h1; RD2D = 32'h2; ImmExtD = 32'h3;
        PCD = 32'h4; PCPlus4D = 32'h8; Rs1D = 5'd1; Rs2D = 5'd2; RdD = 5'd3; Funct3D = 3'd5;
        #1;
        check_all_zero("reset_now");
        cycle("reset_edge1");
        StallE = 1'b0;
        cycle("reset_edge2");
        check_all_zero("reset_held");

        // First capture after release
        rst = 1'b1;
        CtrlD = 12'hA5F; RdD = 5'd7; ValidD = 1'b1;
        cycle("first_load");
        check("first_ctrl", {ValidE, CtrlE, RdE}, {1'b1, 12'hA5F, 5'd7});

        // Stall holds for three cycles
        RD1D = 32'h1234;
        cycle("stall_load");
        RD1D = 32'hFFFF; StallE = 1'b1;
        repeat (3) cycle("stall");
        check("stall_rd1", RD1E, 32'h1234);
        check("stall_cnts", {stall_cnt, bubble_cnt}, {16'd3, 16'd0});

        // Flush beats a simultaneous stall
        FlushE = 1'b1;
        cycle("flush_over_stall");
        check("flush_fields", {ValidE, CtrlE, RdE}, 64'h0);
        check("flush_cnts", {stall_cnt, bubble_cnt}, {16'd3, 16'd1});

        // Invalid instruction keeps data but loses side effects
        FlushE = 1'b0; StallE = 1'b0;
        ValidD = 1'b0; CtrlD = 12'hFFF; RdD = 5'd5; RD2D = 32'h9;
        cycle("invalid_load");
        check("invalid_fields", {ValidE, CtrlE, RdE, RD2E}, {1'b0, 12'h0, 5'd0, 32'h9});

        // Counter saturation on the 4-bit instance
        do_reset();
        StallE = 1'b1; FlushE = 1'b0;
        repeat (20) cycle("sat");
        check("sat_stall4", stall_cnt4, 4'd15);
        check("sat_stall16", stall_cnt, 16'd20);

        // Asynchronous reset mid-stall, between edges
        rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        StallE = 1'b0;

        // Randomized traffic including consecutive flushes and occasional resets
        for (int i = 0; i < 600; i++) begin
            rand_d();
            StallE = ($urandom_range(0, 3) == 0);
            FlushE = ($urandom_range(0, 6) == 0);
            rst    = ($urandom_range(0, 59) != 0);
            cycle("rand");
        end
        rst = 1'b1;
        StallE = 1'b0;
        FlushE = 1'b1;
        repeat (20) cycle("flush_run");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- Decode-to-Execute pipeline register of the 5-stage RV32I core.
- Captures the decode-stage control bundle from the control unit plus register-file/immediate/PC data, and presents them to the Execute stage.
- Implements hazard-unit stall (hold) and flush (bubble insertion) with a valid bit.
- Keeps two saturating performance counters: stall cycles and injected bubbles.

Parameters:
- XLEN, 32, datapath width for operands, immediate and PC.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  core clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (clear when 0).
- StallE  in  1  hazard unit: hold current contents.
- FlushE  in  1  hazard unit: load a bubble; overrides StallE.
- ValidD  in  1  decode-stage instruction is valid.
- CtrlD  in  12  packed control bundle; field layout is in the shared package.
- RD1D  in  XLEN  rs1 read data.
- RD2D  in  XLEN  rs2 read data.
- ImmExtD  in  XLEN  sign-extended immediate.
- PCD  in  XLEN  instruction PC.
- PCPlus4D  in  XLEN  PC+4.
- Rs1D  in  5  source register 1 index.
- Rs2D  in  5  source register 2 index.
- RdD  in  5  destination register index.
- Funct3D  in  3  funct3, used by Execute branch compare.
- ValidE  out  1  Execute-stage instruction is valid.
- CtrlE  out  12  registered control bundle.
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E  out  XLEN each  registered data.
- Rs1E, Rs2E, RdE  out  5 each  registered indices.
- Funct3E  out  3  registered funct3.
- stall_cnt  out  CNT_W  number of cycles with StallE=1 and FlushE=0.
- bubble_cnt  out  CNT_W  number of cycles with FlushE=1.

Behaviour:
- Reset (rst=0, asynchronous, any time including mid-stall): every output, including both counters, is 0 immediately and stays 0 while rst=0.
- First capture is on the first rising edge after rst returns to 1.
- Latency: exactly 1 cycle from the D inputs to the E outputs.
- Update rule at each rising edge, in priority order:
  1. FlushE=1: bubble. ValidE=0; CtrlE=0, so RegWrite, MemWrite, Jump and Branch are all deasserted; Rs1E=Rs2E=RdE=0 so forwarding never matches; data outputs are 0. Applies even when StallE=1 in the same cycle.
  2. StallE=1: every E output holds its value, including ValidE.
  3. Otherwise: load all D inputs; ValidE<=ValidD.
- Load with ValidD=0: CtrlE is forced to 0 and RdE to 0; the data fields are still loaded. An invalid instruction never writes the register file or memory.
- Counters:
  - Both increment by 1 in the same edge as the condition is sampled.
  - Both saturate at 2^CNT_W-1 and never wrap.
  - Only reset clears them.
- The block stores fields only. No decoding or arithmetic is performed on them.
- Consecutive flushes are allowed. Each cycle with FlushE=1 counts one bubble.

Decomposition:
- Shared package (core_pkg): CTRL_W=12 and the field positions of the control bundle:
  - [11] RegWrite
  - [10:9] ResultSrc
  - [8] MemWrite
  - [7] Jump
  - [6:5] Branch
  - [4] ALUSrc
  - [3] sel_adder
  - [2:0] ALUControl
- Also in core_pkg: ResultSrc encodings (00 ALU, 01 mem, 10 PC+4) and the opcode constants.
- One natural sub-module: sat_counter (parameter CNT_W; inputs clk, rst, inc; output count), instantiated twice.

Test Plan:
- Reset: drive all D inputs nonzero with rst=0 -> every output 0, including counters; release rst, CtrlD=12'hA5F, RdD=7, ValidD=1 -> next edge CtrlE=12'hA5F, RdE=7, ValidE=1.
- Stall: load RD1D=32'h1234, then StallE=1 for 3 cycles while RD1D=32'hFFFF -> RD1E stays 32'h1234, stall_cnt=3, bubble_cnt=0.
- Flush over stall: StallE=1 and FlushE=1 for one edge -> ValidE=0, CtrlE=0, RdE=0, bubble_cnt=1, stall_cnt unchanged.
- Invalid load: ValidD=0, CtrlD=12'hFFF, RdD=5, RD2D=32'h9 -> ValidE=0, CtrlE=0, RdE=0, RD2E=32'h9.
- Saturation: CNT_W=4 with StallE held for 20 cycles -> stall_cnt stops at 15.
- Async reset mid-stall: assert rst=0 between clock edges -> outputs go to 0 before the next edge.
